vn_result_pack: RTL and testbench
=================================

VN_RESULT_PACK -- requirements
Module: vn_result_pack

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, PE result valid.
REQ-004 SHALL have port in_ready, output, 1, block accepts a result this cycle.
REQ-005 SHALL have port in_data, input, 32, PE result (full 32b, sign-extended domain).
REQ-006 SHALL have port in_last, input, 1, final element of the vector; forces a flush.
REQ-007 SHALL have port vsew, input, 2, destination element width: 0=8b, 1=16b, 2/3=32b.
REQ-008 SHALL have port is_signed, input, 1, signed (1) or unsigned (0) narrowing.
REQ-009 SHALL have port out_valid, output, 1, packed word valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the word.
REQ-011 SHALL have port out_data, output, 32, packed destination word, lane 0 in bits [W-1:0].
REQ-012 SHALL have port out_be, output, 4, byte enables of the populated lanes.
REQ-013 SHALL have port sat_flag, output, 1, sticky vxsat-style saturation flag.
REQ-014 SHALL have port sat_clr, input, 1, synchronous clear of sat_flag.

Function
REQ-015 SHALL compute lanes per word N = 4/2/1 for vsew 0/1/2-3, with lane width W = 32/N.
REQ-016 SHALL assert in_ready = !out_valid || out_ready; a transfer occurs on in_valid && in_ready.
REQ-017 SHALL latch vsew and is_signed only on a transfer at lane 0, holding them until the word completes.
REQ-018 SHALL narrow each accepted element to W bits (truncation or saturation per REQ-031/032) and write it into lane index lane_cnt of the accumulator.
REQ-019 SHALL increment lane_cnt on a transfer unless the word completes; the word completes when lane_cnt==N-1 or in_last=1.
REQ-020 SHALL, on completion, load out_data with the accumulator plus the new lane, zero the unwritten lanes, set out_be to ones for the written lanes only, set out_valid, and reset lane_cnt and the accumulator to 0.
REQ-021 SHALL present a completed word on the cycle after the completing transfer (latency 1).
REQ-022 SHALL clear out_valid on out_valid && out_ready unless a completion occurs in the same cycle, in which case the new word replaces the old one with out_valid held at 1.
REQ-023 SHALL hold out_data, out_be, and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL treat in_last at lane 0 with vsew=0 as a one-lane word with out_be=4'b0001.
REQ-025 SHALL give sat_clr priority over a same-cycle saturation event when updating sat_flag.

Reset
REQ-026 SHALL, while reset=1, asynchronously force out_valid=0, out_data=0, out_be=0, sat_flag=0, lane_cnt=0, and accumulator=0.
REQ-027 SHALL discard a partially assembled word on reset mid-operation, emitting no flush.
REQ-028 SHALL drive in_ready=1 during and immediately after reset.

Configuration
REQ-029 SHALL compile saturating narrowing in or out under the macro VN_RESULT_PACK_SATURATE_EN.
REQ-030 SHALL, without the macro, truncate to the low W bits, tie sat_flag to 0, and ignore sat_clr.
REQ-031 SHALL, with the macro and is_signed=1, clamp each element to [-2^(W-1), 2^(W-1)-1].
REQ-032 SHALL, with the macro and is_signed=0, clamp each element (treated as unsigned 32b) to 2^W-1.
REQ-033 SHALL, with the macro, set sat_flag whenever a clamp changes a value; the flag is sticky until sat_clr or reset.

Verification
REQ-034 SHALL cover: vsew=0, out_ready=1, four inputs 0x11,0x22,0x33,0x44 (last on the 4th) -> one word 0x44332211, be=1111, one cycle after the 4th transfer.
REQ-035 SHALL cover: vsew=1, inputs 0x1234 then 0xABCD with last -> 0xABCD1234, be=1111; then a single input 0x5555 with last -> 0x00005555, be=0011.
REQ-036 SHALL cover: out_ready=0 with a word pending -> in_ready=0 and out_data stable over 5 cycles; raising out_ready and completing a new word in the same cycle -> out_valid stays 1 and the new word appears.
REQ-037 SHALL cover, with the macro: vsew=0, is_signed=1, input 0x00000100 -> lane 0x7F and sat_flag=1; input 0xFFFFFF00 -> 0x80; assert sat_clr -> sat_flag=0; without the macro the same inputs give 0x00 and sat_flag=0.
REQ-038 SHALL cover: reset asserted after 2 of 4 8b lanes are written -> no word is emitted; the next 4 inputs form a clean word whose lanes hold only the new values.

Source files
------------

// File: rtl/vn_result_pack.sv
// vn_result_pack: narrows 32b PE results to the destination element width and packs them into 32b words.
// Saturating narrowing (and the sticky sat_flag) is compiled in with `define VN_RESULT_PACK_SATURATE_EN.
module vn_result_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [1:0]  vsew,
  input  logic        is_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_be,
  output logic        sat_flag,
  input  logic        sat_clr
);

  logic [1:0]  lane_cnt;
  logic [31:0] acc;
  logic [1:0]  cfg_sew;
  logic        cfg_signed;
  logic [1:0]  eff_sew;
  logic        eff_signed;
  logic        xfer;
  logic        lane_full;
  logic        done;
  logic [7:0]  n8;
  logic [15:0] n16;
  logic [31:0] placed;
  logic [31:0] merged;
  logic [3:0]  be;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  // Lane 0 takes its width/sign straight from the inputs; later lanes use the latched copy.
  assign eff_sew    = (lane_cnt == 2'd0) ? vsew : cfg_sew;
  assign eff_signed = (lane_cnt == 2'd0) ? is_signed : cfg_signed;

`ifdef VN_RESULT_PACK_SATURATE_EN
  logic fits8_s;
  logic fits8_u;
  logic fits16_s;
  logic fits16_u;
  logic sat8;
  logic sat16;
  logic sat_evt;

  assign fits8_s  = (in_data[31:7] == '0) || (in_data[31:7] == '1);
  assign fits8_u  = (in_data[31:8] == '0);
  assign fits16_s = (in_data[31:15] == '0) || (in_data[31:15] == '1);
  assign fits16_u = (in_data[31:16] == '0);

  always_comb begin
    n8   = in_data[7:0];
    sat8 = 1'b0;
    if (eff_signed) begin
      if (!fits8_s) begin
        sat8 = 1'b1;
        n8   = in_data[31] ? 8'h80 : 8'h7F;
      end
    end else if (!fits8_u) begin
      sat8 = 1'b1;
      n8   = 8'hFF;
    end
  end

  always_comb begin
    n16   = in_data[15:0];
    sat16 = 1'b0;
    if (eff_signed) begin
      if (!fits16_s) begin
        sat16 = 1'b1;
        n16   = in_data[31] ? 16'h8000 : 16'h7FFF;
      end
    end else if (!fits16_u) begin
      sat16 = 1'b1;
      n16   = 16'hFFFF;
    end
  end

  assign sat_evt = xfer && (((eff_sew == 2'd0) && sat8) || ((eff_sew == 2'd1) && sat16));

  // Clear wins over a saturation in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag <= 1'b0;
    end else if (sat_clr) begin
      sat_flag <= 1'b0;
    end else if (sat_evt) begin
      sat_flag <= 1'b1;
    end
  end
`else
  logic unused_sat_inputs;

  assign n8       = in_data[7:0];
  assign n16      = in_data[15:0];
  assign sat_flag = 1'b0;
  assign unused_sat_inputs = &{1'b0, sat_clr, eff_signed};
`endif

  always_comb begin
    placed = '0;
    case (eff_sew)
      2'd0:    placed = {24'd0, n8} << {lane_cnt, 3'b000};
      2'd1:    placed = {16'd0, n16} << {lane_cnt[0], 4'b0000};
      default: placed = in_data;
    endcase
  end

  // Unwritten lanes of acc are always zero, so OR-ing in the new lane is enough.
  assign merged = acc | placed;

  always_comb begin
    lane_full = 1'b1;
    be        = 4'b1111;
    case (eff_sew)
      2'd0: begin
        lane_full = (lane_cnt == 2'd3);
        case (lane_cnt)
          2'd0:    be = 4'b0001;
          2'd1:    be = 4'b0011;
          2'd2:    be = 4'b0111;
          default: be = 4'b1111;
        endcase
      end
      2'd1: begin
        lane_full = lane_cnt[0];
        be        = lane_cnt[0] ? 4'b1111 : 4'b0011;
      end
      default: begin
        lane_full = 1'b1;
        be        = 4'b1111;
      end
    endcase
  end

  assign done = lane_full || in_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_cnt   <= 2'd0;
      acc        <= '0;
      cfg_sew    <= 2'd0;
      cfg_signed <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_be     <= 4'b0000;
    end else begin
      if (xfer && (lane_cnt == 2'd0)) begin
        cfg_sew    <= vsew;
        cfg_signed <= is_signed;
      end
      if (xfer) begin
        if (done) begin
          out_data <= merged;
          out_be   <= be;
          lane_cnt <= 2'd0;
          acc      <= '0;
        end else begin
          acc      <= merged;
          lane_cnt <= lane_cnt + 2'd1;
        end
      end
      // A completion in the same cycle as a pop replaces the word without a bubble.
      if (xfer && done) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vn_result_pack.sv
// Bench for vn_result_pack: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an element-list reference model.
module tb_vn_result_pack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [1:0]  vsew = 2'd0;
  logic        is_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        sat_flag;
  logic        sat_clr = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit checking = 1'b0;

`ifdef VN_RESULT_PACK_SATURATE_EN
  localparam logic [31:0] EXP_POS = 32'h0000_007F;
  localparam logic [31:0] EXP_NEG = 32'h0000_0080;
  localparam logic [31:0] EXP_SAT = 32'd1;
`else
  localparam logic [31:0] EXP_POS = 32'h0000_0000;
  localparam logic [31:0] EXP_NEG = 32'h0000_0000;
  localparam logic [31:0] EXP_SAT = 32'd0;
`endif

  vn_result_pack dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .vsew(vsew), .is_signed(is_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_be(out_be), .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: collect narrowed elements; a word is the elements laid side by side.
  bit          m_valid = 1'b0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_be = '0;
  bit          m_sat = 1'b0;
  int          m_n = 0;
  int          m_lanes = 1;
  bit          m_sgn = 1'b0;
  logic [31:0] m_elem [4];

  function automatic void narrow(input logic [31:0] d, input int w, input bit sgn,
                                 output logic [31:0] v, output bit c);
    longint x, lo, hi;
    c = 1'b0;
    if (w == 32) begin
      v = d;
      return;
    end
    v = d & ((32'd1 << w) - 32'd1);
`ifdef VN_RESULT_PACK_SATURATE_EN
    if (sgn) begin
      x  = $signed(d);
      lo = -(longint'(1) << (w - 1));
      hi = (longint'(1) << (w - 1)) - 1;
    end else begin
      x  = {32'd0, d};
      lo = 0;
      hi = (longint'(1) << w) - 1;
    end
    if (x > hi) begin
      v = 32'(hi);
      c = 1'b1;
    end else if (x < lo) begin
      v = 32'(lo) & ((32'd1 << w) - 32'd1);
      c = 1'b1;
    end
`else
    x = 0; lo = 0; hi = 0;
    if (sgn) c = 1'b0;
`endif
  endfunction

  task automatic model_step();
    bit xfer, done, clamped;
    logic [31:0] v, word;
    int w;
    xfer = in_valid && (!m_valid || out_ready);
    done = 1'b0;
    clamped = 1'b0;
    if (xfer) begin
      if (m_n == 0) begin
        m_lanes = (vsew == 2'd0) ? 4 : (vsew == 2'd1) ? 2 : 1;
        m_sgn   = is_signed;
      end
      w = 32 / m_lanes;
      narrow(in_data, w, m_sgn, v, clamped);
      m_elem[m_n] = v;
      m_n++;
      if (m_n == m_lanes || in_last) begin
        word = '0;
        for (int i = 0; i < m_n; i++) word = word | (m_elem[i] << (i * w));
        m_data  = word;
        m_be    = 4'((1 << (m_n * w / 8)) - 1);
        m_valid = 1'b1;
        m_n     = 0;
        done    = 1'b1;
      end
    end
    if (!done && out_ready) m_valid = 1'b0;
    if (sat_clr) m_sat = 1'b0;
    else if (xfer && clamped) m_sat = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_be = '0; m_sat = 1'b0; m_n = 0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      chk("sat_flag", 32'(sat_flag), 32'(m_sat));
      if (m_valid) begin
        chk("out_data", out_data, m_data);
        chk("out_be", 32'(out_be), 32'(m_be));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [31:0] d, input bit last, input logic [1:0] sew, input bit sgn);
    bit rdy, got;
    got = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last; vsew = sew; is_signed = sgn;
    for (int k = 0; k < 50 && !got; k++) begin
      #1 rdy = in_ready;
      @(posedge clk); #1;
      got = rdy;
    end
    if (!got) chk("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] edges [10];
    logic [31:0] r;
    edges = '{32'h7F, 32'h80, 32'hFF, 32'h100, 32'h7FFF, 32'h8000, 32'hFFFF,
              32'h10000, 32'hFFFFFF80, 32'hFFFF8000};
    case ($urandom_range(0, 4))
      0: r = $urandom_range(0, 300);
      1: r = 32'(-int'($urandom_range(0, 300)));
      2: r = $urandom;
      3: r = edges[$urandom_range(0, 9)];
      default: r = $urandom_range(0, 70000);
    endcase
    return r;
  endfunction

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_be", 32'(out_be), 32'd0);
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    checking = 1'b1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // four byte lanes
    push(32'h11, 0, 2'd0, 0); push(32'h22, 0, 2'd0, 0);
    push(32'h33, 0, 2'd0, 0); push(32'h44, 1, 2'd0, 0);
    chk("b4_valid", 32'(out_valid), 32'd1);
    chk("b4_data", out_data, 32'h44332211);
    chk("b4_be", 32'(out_be), 32'hF);
    idle();

    // halfword lanes, then a one-lane flush
    push(32'h1234, 0, 2'd1, 0); push(32'hABCD, 1, 2'd1, 0);
    chk("h2_data", out_data, 32'hABCD1234);
    chk("h2_be", 32'(out_be), 32'hF);
    push(32'h5555, 1, 2'd1, 0);
    chk("h1_data", out_data, 32'h00005555);
    chk("h1_be", 32'(out_be), 32'h3);
    idle();

    // backpressure, then pop and replace in one cycle
    out_ready = 1'b0;
    push(32'hCAFEF00D, 1, 2'd2, 0);
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", out_data, 32'hCAFEF00D);
      idle();
    end
    out_ready = 1'b1;
    push(32'h12345678, 1, 2'd2, 0);
    chk("repl_valid", 32'(out_valid), 32'd1);
    chk("repl_data", out_data, 32'h12345678);
    idle();

    // signed byte narrowing
    push(32'h00000100, 1, 2'd0, 1);
    chk("sat_pos_data", out_data, EXP_POS);
    chk("sat_pos_be", 32'(out_be), 32'h1);
    chk("sat_pos_flag", 32'(sat_flag), EXP_SAT);
    push(32'hFFFFFF00, 1, 2'd0, 1);
    chk("sat_neg_data", out_data, EXP_NEG);
    chk("sat_neg_flag", 32'(sat_flag), EXP_SAT);
    idle();
    sat_clr = 1'b1;
    idle();
    sat_clr = 1'b0;
    chk("sat_clr_flag", 32'(sat_flag), 32'd0);

    // reset mid-word discards the partial lanes
    push(32'hAA, 0, 2'd0, 0); push(32'hBB, 0, 2'd0, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    idle(); idle();
    reset = 1'b0;
    idle();
    chk("after_rst_valid", 32'(out_valid), 32'd0);
    push(32'h01, 0, 2'd0, 0); push(32'h02, 0, 2'd0, 0); push(32'h03, 0, 2'd0, 0);
    chk("partial_no_emit", 32'(out_valid), 32'd0);
    push(32'h04, 1, 2'd0, 0);
    chk("clean_data", out_data, 32'h04030201);
    chk("clean_be", 32'(out_be), 32'hF);
    idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_data();
      in_last   = ($urandom_range(0, 5) == 0);
      vsew      = 2'($urandom_range(0, 3));
      is_signed = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      sat_clr   = ($urandom_range(0, 15) == 0);
      if (i == 1500) reset = 1'b1;
      if (i == 1502) reset = 1'b0;
      idle();
    end
    in_valid = 1'b0; in_last = 1'b0; sat_clr = 1'b0; out_ready = 1'b1;
    idle(); idle();
    checking = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
